// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the scoreboarded register file.
// Optional write-through forwarding is enabled by REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NREG_DEF     = 32;
  localparam int LINK_REG_DEF = 31;
  localparam int POP_W        = 128;

  typedef logic [XLEN_DEF-1:0] word_t;

  function automatic logic [7:0] popcount(
    input logic [POP_W-1:0] v
  );
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < POP_W; i++)
      n = n + {7'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bit per register, WAW detection and pending count.
// Issue beats a same-cycle write; flush beats both.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wt,
  input  logic          flush,
  output logic [NREG-1:0] pend,
  output logic          waw_err,
  output logic [AW:0]   pend_cnt
);

  localparam int CW = AW + 1;

  logic [NREG-1:0]  pend_q, pend_d;
  logic             waw_q, waw_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [POP_W-1:0] pend_ext;
  logic             iss_ok;

  assign iss_ok = issue_en && (issue_addr != '0);

  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (wr_en && (wt != '0))
        pend_d[wt] = 1'b0;
      if (iss_ok)
        pend_d[issue_addr] = 1'b1;
    end
  end

  always_comb begin
    pend_ext = '0;
    pend_ext[NREG-1:0] = pend_d;
    cnt_d = CW'(popcount(pend_ext));
    waw_d = iss_ok && !flush && pend_q[issue_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      waw_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      waw_q  <= waw_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend     = pend_q;
  assign waw_err  = waw_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// N-read-port register file with scoreboard and link-register write path.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback to readers.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int LINK_REG = LINK_REG_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              link_en,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  input  logic              flush,
  output logic              waw_err,
  output logic [AW:0]       pend_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [AW-1:0]   wt;
  logic            wr_hit;
  logic [NREG-1:0] pend;

  assign wt     = link_en ? AW'(LINK_REG) : wr_addr;
  assign wr_hit = wr_en && (wt != '0);

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wt         (wt),
    .flush      (flush),
    .pend       (pend),
    .waw_err    (waw_err),
    .pend_cnt   (pend_cnt)
  );

  always_comb begin
    regs_d = regs_q;
    if (wr_hit)
      regs_d[wt] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      regs_q <= '{default: '0};
    else
      regs_q <= regs_d;
  end

  always_comb begin
    logic [AW-1:0] ra;
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      rd_data[k*XLEN +: XLEN] = regs_q[ra];
      rd_busy[k] = pend[ra];
`ifdef REGFILE_BYPASS_EN
      // a fresh issue to the same register keeps it busy
      if (wr_hit && (ra == wt)) begin
        rd_data[k*XLEN +: XLEN] = wr_data;
        rd_busy[k] = issue_en && (issue_addr == ra);
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, corner sequences, random.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  word_t       wr_data;
  logic        link_en;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        flush;
  logic        waw_err;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .link_en    (link_en),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .waw_err    (waw_err),
    .pend_cnt   (pend_cnt)
  );

  // reference model: architectural state only
  word_t      m_reg [32];
  bit  [31:0] m_pend;
  bit         m_waw;
  wire [4:0]  m_wt = link_en ? 5'd31 : wr_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] <= '0;
      m_pend <= '0;
      m_waw  <= 1'b0;
    end else begin
      if (wr_en && m_wt != 0) m_reg[m_wt] <= wr_data;
      m_waw <= issue_en && !flush && issue_addr != 0
               && m_pend[issue_addr];
      for (int r = 0; r < 32; r++) begin
        if (flush) m_pend[r] <= 1'b0;
        else if (issue_en && issue_addr == r && r != 0) m_pend[r] <= 1'b1;
        else if (wr_en && m_wt == r) m_pend[r] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] a;
      word_t ed;
      logic eb;
      a  = rd_addr[k*5 +: 5];
      ed = (a == 0) ? '0 : m_reg[a];
      eb = m_pend[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && m_wt != 0 && a == m_wt) begin
        ed = wr_data;
        eb = issue_en && issue_addr == a;
      end
`endif
      chk($sformatf("mdl_data%0d", k), rd_data[k*32 +: 32], ed);
      chk($sformatf("mdl_busy%0d", k), {31'd0, rd_busy[k]}, {31'd0, eb});
    end
    chk("mdl_waw", {31'd0, waw_err}, {31'd0, m_waw});
    chk("mdl_cnt", {26'd0, pend_cnt}, $countones(m_pend));
  endtask

  task automatic idle();
    wr_en = 0; link_en = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_addr = 0; flush = 0;
  endtask

  typedef struct {
    logic we, le; logic [4:0] wa; logic [31:0] wd;
    logic ie; logic [4:0] ia; logic fl;
    logic [4:0] ra0, ra1;
    logic [31:0] d0; logic b0; logic [31:0] d1;
    logic waw; logic [5:0] cnt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1,0,0,32'h12345678,1,0,0, 0,0, 0,0,0,0,0};
    vecs[1]  = '{1,1,7,32'h00400010,0,0,0, 31,7, 32'h00400010,0,0,0,0};
    vecs[2]  = '{0,0,0,0,1,3,0, 3,31, 0,1,32'h00400010,0,1};
    vecs[3]  = '{0,0,0,0,1,3,0, 3,7, 0,1,0,1,1};
    vecs[4]  = '{0,0,0,0,0,0,0, 3,7, 0,1,0,0,1};
    vecs[5]  = '{1,0,3,32'h33,0,0,0, 3,7, 32'h33,0,0,0,0};
    vecs[6]  = '{0,0,0,0,1,9,0, 9,7, 0,1,0,0,1};
    vecs[7]  = '{1,0,9,32'h99,1,9,0, 9,7, 32'h99,1,0,1,1};
    vecs[8]  = '{0,0,0,0,1,2,0, 2,9, 0,1,32'h99,0,2};
    vecs[9]  = '{0,0,0,0,1,4,0, 4,9, 0,1,32'h99,0,3};
    vecs[10] = '{0,0,0,0,1,5,1, 9,4, 32'h99,0,0,0,0};
    vecs[11] = '{0,0,0,0,1,6,0, 6,7, 0,1,0,0,1};

    idle();
    rd_addr = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_data0", rd_data[31:0], 32'h0);
    chk("rst_busy", {30'd0, rd_busy}, 32'h0);
    chk("rst_cnt", {26'd0, pend_cnt}, 32'h0);
    chk("rst_waw", {31'd0, waw_err}, 32'h0);

    // async reset clears live contents and pending state mid-cycle
    @(negedge clk);
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    issue_en = 1; issue_addr = 5; rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    idle();
    #1;
    chk("pre_rst_r5", rd_data[31:0], 32'hDEADBEEF);
    chk("pre_rst_cnt", {26'd0, pend_cnt}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_r5", rd_data[31:0], 32'h0);
    chk("async_rst_cnt", {26'd0, pend_cnt}, 32'h0);
    chk("async_rst_busy", {31'd0, rd_busy[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].we; link_en = vecs[i].le;
      wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      issue_en = vecs[i].ie; issue_addr = vecs[i].ia;
      flush = vecs[i].fl;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_d0", i), rd_data[31:0], vecs[i].d0);
      chk($sformatf("v%0d_b0", i), {31'd0, rd_busy[0]}, {31'd0, vecs[i].b0});
      chk($sformatf("v%0d_d1", i), rd_data[63:32], vecs[i].d1);
      chk($sformatf("v%0d_waw", i), {31'd0, waw_err}, {31'd0, vecs[i].waw});
      chk($sformatf("v%0d_cnt", i), {26'd0, pend_cnt}, {26'd0, vecs[i].cnt});
      check_model();
    end

    // same-cycle read of a register being written back (r6 pending)
    idle();
    wr_en = 1; wr_addr = 6; wr_data = 32'hCAFEF00D;
    rd_addr = {5'd0, 5'd6};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", rd_data[31:0], 32'hCAFEF00D);
    chk("byp_busy", {31'd0, rd_busy[0]}, 32'h0);
`else
    chk("nobyp_data", rd_data[31:0], 32'h0);
    chk("nobyp_busy", {31'd0, rd_busy[0]}, 32'h1);
`endif
    @(negedge clk);
    idle();
    #1;
    chk("post_wb_data", rd_data[31:0], 32'hCAFEF00D);
    chk("post_wb_busy", {31'd0, rd_busy[0]}, 32'h0);
    chk("post_wb_cnt", {26'd0, pend_cnt}, 32'h0);

    // random traffic biased to a few registers to provoke hazards
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wr_en      = ($urandom_range(0, 2) != 0);
      link_en    = ($urandom_range(0, 7) == 0);
      wr_addr    = 5'($urandom_range(0, 9));
      wr_data    = $urandom;
      issue_en   = ($urandom_range(0, 1) != 0);
      issue_addr = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
      flush      = ($urandom_range(0, 19) == 0);
      rd_addr    = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 10))};
      #1;
      check_model();
    end

    @(negedge clk);
    idle();
    #1;
    check_model();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined datapath; successor to the single-cycle two-read/one-write file.
- Adds N read ports, a per-register scoreboard (pending-write bits) for hazard detection, and a dedicated link-register write path for jal/jalr.
- Sits between decode (reads, issue) and writeback (write, retire); decode stalls on rd_busy.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, register count; power of two, >= 4.
- AW, $clog2(NREG), address width; derived, never overridden.
- NRD, 2, number of read ports, 1..4.
- LINK_REG, 31, index written when link_en is high; must be nonzero and < NREG.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port k at [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  port k's register has a pending write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback target; ignored when link_en=1.
- wr_data  in  XLEN  writeback data.
- link_en  in  1  with wr_en, redirects the write to LINK_REG.
- issue_en  in  1  decode issues an instruction that will write issue_addr.
- issue_addr  in  AW  destination being reserved.
- flush  in  1  synchronous clear of all pending bits (branch mispredict).
- waw_err  out  1  registered; issue to an already-pending register.
- pend_cnt  out  AW+1  registered count of pending registers.

Behaviour:
- Reset (async, on rst high): all registers 0, all pending bits 0, waw_err=0, pend_cnt=0. rd_data then reads 0 and rd_busy reads 0.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and issues to register 0 are dropped: no state change, no waw_err.
- Effective write target: wt = link_en ? LINK_REG : wr_addr.
  - On posedge with wr_en=1 and wt!=0: reg[wt] <= wr_data.
- Read: rd_data[k] = reg[rd_addr[k]], combinational, zero latency. A write becomes visible the cycle after its edge unless bypass is enabled (see Optional Feature).
- Scoreboard, per-register next state at each edge, evaluated in priority order:
  - flush=1: every pending bit -> 0. Same-cycle issue and write still update the register contents but do not set any pending bit.
  - Otherwise issue_en=1 and issue_addr=r (r!=0): pending[r] -> 1. An issue wins over a same-cycle write to the same r, because the new producer is still outstanding.
  - Otherwise wr_en=1 and wt=r: pending[r] -> 0.
  - Otherwise hold.
- waw_err: the next-cycle value is issue_en & ~flush & (issue_addr!=0) & pending[issue_addr]. It is a one-cycle pulse; pending stays 1.
- pend_cnt: popcount of the pending vector after the update; maximum value NREG-1.
- rd_busy[k] = pending[rd_addr[k]], combinational from current state.
- A write to a non-pending register is legal. Contents update and the scoreboard is unchanged.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: when wr_en=1, wt!=0 and rd_addr[k]==wt in the same cycle:
  - rd_data[k] = wr_data (write-through);
  - rd_busy[k] = 0 unless issue_en targets the same register that cycle.
- Undefined: no forwarding; reads show the old value and rd_busy stays 1 until the edge.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEF, NREG_DEF, LINK_REG_DEF constants;
  - typedef word_t (logic [XLEN_DEF-1:0]);
  - a popcount function.
- Sub-module regfile_scoreboard owns the pending vector, waw_err and pend_cnt.
- The top level holds the storage array, read muxing and bypass.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst mid-cycle -> rd_data for r5 is 0 immediately (async), pend_cnt=0.
- r0 protection: wr_en with wr_addr=0 and data 0x12345678, issue_addr=0 -> r0 reads 0, rd_busy=0, waw_err=0, pend_cnt unchanged.
- Link write: wr_en=1, link_en=1, wr_addr=7, wr_data=0x00400010 -> r31=0x00400010, r7 unchanged.
- Scoreboard: issue r3 -> next cycle rd_busy(r3)=1, pend_cnt=1. Issue r3 again -> waw_err pulses one cycle. Write r3 -> busy clears, pend_cnt=0.
- Simultaneous issue and write on r9 with r9 pending -> r9 stays pending, data updated. Then flush with r2, r4, r9 pending -> pend_cnt=0 the next cycle.
- Bypass (with REGFILE_BYPASS_EN): read r6 while writing 0xCAFEF00D to r6 -> same-cycle rd_data=0xCAFEF00D, rd_busy=0. Without the macro -> old value, rd_busy=1.
